// File: rtl/ucsbece154b_bpu_gshare.sv
// ---------------------------------------------------------------------------
// ucsbece154b_bpu_gshare
//
// Fetch-stage branch prediction unit for the 5-stage RV32 pipeline.
// It combines a tagged, direct-mapped BTB with a gshare pattern history
// table (PHT) that is indexed by PC xor a speculative global history
// register (GHR). Lookup is purely combinational on the fetch PC. All
// training (BTB, PHT, GHR recovery) happens from the E-stage update port.
// The GHR value seen at fetch is exported as a checkpoint. That checkpoint
// travels down the pipe and comes back on a mispredict so the history can
// be repaired.
//
// Optional feature macro: BPU_PERF_EN
//   defined   -> two saturating 32-bit performance counters are built
//   undefined -> perf_branches_o / perf_mispred_o are tied to zero
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   pc_f_i                fetch PC
//   stall_f_i             fetch stalled (freezes speculative GHR shift)
//   pred_taken_f_o        predicted redirect
//   pred_target_f_o       BTB target of the indexed entry
//   pht_idx_f_o           PHT index used by this lookup (piped to E)
//   ghr_snap_f_o          GHR before this fetch's shift (piped to E)
//   upd_*_e_i             E-stage resolution / training inputs
//   perf_branches_o       resolved branch + jump count
//   perf_mispred_o        mispredict count
// ---------------------------------------------------------------------------
module ucsbece154b_bpu_gshare #(
  parameter int NUM_BTB_ENTRIES = 64,
  parameter int BTB_TAG_BITS    = 8,
  parameter int NUM_GHR_BITS    = 6,
  parameter int CTR_BITS        = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             pc_f_i,
  input  logic                    stall_f_i,
  output logic                    pred_taken_f_o,
  output logic [31:0]             pred_target_f_o,
  output logic [NUM_GHR_BITS-1:0] pht_idx_f_o,
  output logic [NUM_GHR_BITS-1:0] ghr_snap_f_o,
  input  logic                    upd_valid_e_i,
  input  logic [31:0]             upd_pc_e_i,
  input  logic                    upd_is_branch_e_i,
  input  logic                    upd_is_jump_e_i,
  input  logic                    upd_taken_e_i,
  input  logic [31:0]             upd_target_e_i,
  input  logic [NUM_GHR_BITS-1:0] upd_pht_idx_e_i,
  input  logic [NUM_GHR_BITS-1:0] upd_ghr_snap_e_i,
  input  logic                    upd_mispredict_e_i,
  output logic [31:0]             perf_branches_o,
  output logic [31:0]             perf_mispred_o
);

  localparam int IDX         = $clog2(NUM_BTB_ENTRIES);
  localparam int PHT_ENTRIES = 1 << NUM_GHR_BITS;
  localparam int TAG_LO      = IDX + 2;
  localparam int TAG_HI      = IDX + BTB_TAG_BITS + 1;

  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = {{(CTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

  // Storage
  logic                    btbValid_q  [NUM_BTB_ENTRIES];
  logic [BTB_TAG_BITS-1:0] btbTag_q    [NUM_BTB_ENTRIES];
  logic [31:0]             btbTarget_q [NUM_BTB_ENTRIES];
  logic                    btbJump_q   [NUM_BTB_ENTRIES];
  logic [CTR_BITS-1:0]     pht_q       [PHT_ENTRIES];
  logic [NUM_GHR_BITS-1:0] ghr_q;
  logic [NUM_GHR_BITS-1:0] ghr_d;

  // Fetch-side lookup signals
  logic [IDX-1:0]          fetchIdx;
  logic [BTB_TAG_BITS-1:0] fetchTag;
  logic                    fetchHit;
  logic                    fetchIsJump;
  logic [NUM_GHR_BITS-1:0] fetchPhtIdx;
  logic                    fetchCtrTaken;
  logic                    fetchPredTaken;

  // Update-side signals
  logic [IDX-1:0]          updIdx;
  logic [BTB_TAG_BITS-1:0] updTag;
  logic                    btbWrite;
  logic                    phtWrite;
  logic                    recover;
  logic [CTR_BITS-1:0]     phtCur;
  logic [CTR_BITS-1:0]     phtNext_d;

  // PC bits that never take part in indexing or tagging.
  logic unusedPcBits;
  assign unusedPcBits = ^{pc_f_i[1:0], pc_f_i[31:TAG_HI+1],
                          upd_pc_e_i[1:0], upd_pc_e_i[31:TAG_HI+1]};

  // Combinational fetch lookup. The BTB target is driven out even on a
  // miss or a not-taken prediction; the datapath only uses it when
  // pred_taken_f_o is set.
  assign fetchIdx       = pc_f_i[IDX+1:2];
  assign fetchTag       = pc_f_i[TAG_HI:TAG_LO];
  assign fetchHit       = btbValid_q[fetchIdx] && (btbTag_q[fetchIdx] == fetchTag);
  assign fetchIsJump    = btbJump_q[fetchIdx];
  assign fetchPhtIdx    = pc_f_i[NUM_GHR_BITS+1:2] ^ ghr_q;
  assign fetchCtrTaken  = pht_q[fetchPhtIdx][CTR_BITS-1];
  assign fetchPredTaken = fetchHit && (fetchIsJump || fetchCtrTaken);

  assign pred_taken_f_o  = fetchPredTaken;
  assign pred_target_f_o = btbTarget_q[fetchIdx];
  assign pht_idx_f_o     = fetchPhtIdx;
  assign ghr_snap_f_o    = ghr_q;

  // Update-side decode. Only taken control flow allocates in the BTB, so
  // not-taken branches never evict a useful entry.
  assign updIdx   = upd_pc_e_i[IDX+1:2];
  assign updTag   = upd_pc_e_i[TAG_HI:TAG_LO];
  assign btbWrite = upd_valid_e_i && (upd_is_jump_e_i || (upd_is_branch_e_i && upd_taken_e_i));
  assign phtWrite = upd_valid_e_i && upd_is_branch_e_i;
  assign recover  = upd_valid_e_i && upd_mispredict_e_i;

  // Saturating counter step for the PHT entry named by the piped index.
  // The counter sticks at both ends instead of wrapping, so a long run of
  // one outcome cannot flip the prediction on the next opposite outcome.
  always_comb begin
    phtCur    = pht_q[upd_pht_idx_e_i];
    phtNext_d = phtCur;
    if (upd_taken_e_i) begin
      if (phtCur != CTR_MAX) phtNext_d = phtCur + CTR_ONE;
    end else begin
      if (phtCur != CTR_ZERO) phtNext_d = phtCur - CTR_ONE;
    end
  end

  // Next GHR. Fetch speculatively shifts in its own prediction for
  // conditional branches that hit. A mispredict from E rebuilds history
  // from the checkpoint the instruction carried. It is assigned last so
  // it overrides any shift from the same cycle, because that fetch is on
  // the wrong path anyway. Jumps contribute no history bit.
  always_comb begin
    ghr_d = ghr_q;
    if (!stall_f_i && fetchHit && !fetchIsJump) begin
      ghr_d = {ghr_q[NUM_GHR_BITS-2:0], fetchPredTaken};
    end
    if (recover) begin
      if (upd_is_branch_e_i) begin
        ghr_d = {upd_ghr_snap_e_i[NUM_GHR_BITS-2:0], upd_taken_e_i};
      end else begin
        ghr_d = upd_ghr_snap_e_i;
      end
    end
  end

  // GHR register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // BTB storage. Reset clears the targets as well as the valid bits, so
  // the target output reads zero until training occurs. A write lands at
  // the clock edge, so a fetch lookup in the same cycle still sees the
  // old entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) begin
        btbValid_q[i]  <= 1'b0;
        btbTag_q[i]    <= '0;
        btbTarget_q[i] <= '0;
        btbJump_q[i]   <= 1'b0;
      end
    end else if (btbWrite) begin
      btbValid_q[updIdx]  <= 1'b1;
      btbTag_q[updIdx]    <= updTag;
      btbTarget_q[updIdx] <= upd_target_e_i;
      btbJump_q[updIdx]   <= upd_is_jump_e_i;
    end
  end

  // PHT storage. Every counter resets to weakly not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_q[i] <= CTR_INIT;
      end
    end else if (phtWrite) begin
      pht_q[upd_pht_idx_e_i] <= phtNext_d;
    end
  end

`ifdef BPU_PERF_EN
  logic [31:0] perfBranches_q;
  logic [31:0] perfBranches_d;
  logic [31:0] perfMispred_q;
  logic [31:0] perfMispred_d;

  // Saturating event counters for resolved control flow and mispredicts.
  always_comb begin
    perfBranches_d = perfBranches_q;
    perfMispred_d  = perfMispred_q;
    if (upd_valid_e_i && (upd_is_branch_e_i || upd_is_jump_e_i) &&
        (perfBranches_q != 32'hFFFF_FFFF)) begin
      perfBranches_d = perfBranches_q + 32'd1;
    end
    if (recover && (perfMispred_q != 32'hFFFF_FFFF)) begin
      perfMispred_d = perfMispred_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perfBranches_q <= '0;
      perfMispred_q  <= '0;
    end else begin
      perfBranches_q <= perfBranches_d;
      perfMispred_q  <= perfMispred_d;
    end
  end

  assign perf_branches_o = perfBranches_q;
  assign perf_mispred_o  = perfMispred_q;
`else
  assign perf_branches_o = 32'd0;
  assign perf_mispred_o  = 32'd0;
`endif

endmodule

// File: tb/tb_ucsbece154b_bpu_gshare.sv
// ---------------------------------------------------------------------------
// tb_ucsbece154b_bpu_gshare
//
// Directed and then randomised stimulus for the gshare BPU at its default
// parameters. Each step drives the fetch and update ports after a falling
// edge. The step pushes the expected combinational outputs, computed by a
// small reference model, onto a scoreboard queue. It then pops and
// compares them before the next rising edge. Constant checks pin down the
// key scenarios independently of the model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ucsbece154b_bpu_gshare;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pcF;
  logic        stallF;
  logic        predTaken;
  logic [31:0] predTarget;
  logic [5:0]  phtIdx;
  logic [5:0]  ghrSnap;
  logic        updValid;
  logic [31:0] updPc;
  logic        updIsBranch;
  logic        updIsJump;
  logic        updTaken;
  logic [31:0] updTarget;
  logic [5:0]  updPhtIdx;
  logic [5:0]  updGhrSnap;
  logic        updMispredict;
  logic [31:0] perfBranches;
  logic [31:0] perfMispred;

  ucsbece154b_bpu_gshare dut (
    .clk                (clk),
    .reset              (reset),
    .pc_f_i             (pcF),
    .stall_f_i          (stallF),
    .pred_taken_f_o     (predTaken),
    .pred_target_f_o    (predTarget),
    .pht_idx_f_o        (phtIdx),
    .ghr_snap_f_o       (ghrSnap),
    .upd_valid_e_i      (updValid),
    .upd_pc_e_i         (updPc),
    .upd_is_branch_e_i  (updIsBranch),
    .upd_is_jump_e_i    (updIsJump),
    .upd_taken_e_i      (updTaken),
    .upd_target_e_i     (updTarget),
    .upd_pht_idx_e_i    (updPhtIdx),
    .upd_ghr_snap_e_i   (updGhrSnap),
    .upd_mispredict_e_i (updMispredict),
    .perf_branches_o    (perfBranches),
    .perf_mispred_o     (perfMispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        uv;
    logic [31:0] upc;
    logic        ub;
    logic        uj;
    logic        ut;
    logic [31:0] utgt;
    logic [5:0]  uidx;
    logic [5:0]  usnap;
    logic        um;
  } stim_t;

  typedef struct {
    logic        taken;
    logic [31:0] target;
    logic [5:0]  idx;
    logic [5:0]  snap;
    logic [31:0] perfBr;
    logic [31:0] perfMis;
  } exp_t;

  exp_t expQ[$];

  // Reference model state
  logic        mValid  [64];
  logic [7:0]  mTag    [64];
  logic [31:0] mTarget [64];
  logic        mJump   [64];
  logic [1:0]  mPht    [64];
  logic [5:0]  mGhr;
  logic [31:0] mBr;
  logic [31:0] mMis;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;
  int stepNo     = 0;

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s step=%0d observed=0x%0h expected=0x%0h", tag, stepNo, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 64; i++) begin
      mValid[i]  = 1'b0;
      mTag[i]    = 8'd0;
      mTarget[i] = 32'd0;
      mJump[i]   = 1'b0;
      mPht[i]    = 2'd1;
    end
    mGhr = 6'd0;
    mBr  = 32'd0;
    mMis = 32'd0;
  endtask

  function automatic exp_t modelPredict(input stim_t s);
    exp_t       e;
    logic [5:0] bi;
    logic       hit;
    bi       = s.pc[7:2];
    hit      = mValid[bi] && (mTag[bi] == s.pc[15:8]);
    e.idx    = s.pc[7:2] ^ mGhr;
    e.taken  = hit && (mJump[bi] || mPht[e.idx][1]);
    e.target = mTarget[bi];
    e.snap   = mGhr;
`ifdef BPU_PERF_EN
    e.perfBr  = mBr;
    e.perfMis = mMis;
`else
    e.perfBr  = 32'd0;
    e.perfMis = 32'd0;
`endif
    return e;
  endfunction

  // Advance the model by the clock edge that follows a step.
  task automatic modelCommit(input stim_t s);
    exp_t       e;
    logic [5:0] bi;
    logic       hit;
    logic [5:0] ng;
    if (s.rst) begin
      modelReset();
    end else begin
      e   = modelPredict(s);
      bi  = s.pc[7:2];
      hit = mValid[bi] && (mTag[bi] == s.pc[15:8]);
      ng  = mGhr;
      if (!s.stall && hit && !mJump[bi]) ng = {mGhr[4:0], e.taken};
      if (s.uv && s.um) ng = s.ub ? {s.usnap[4:0], s.ut} : s.usnap;
      if (s.uv && s.ub) begin
        if (s.ut && mPht[s.uidx] != 2'd3) mPht[s.uidx] = mPht[s.uidx] + 2'd1;
        else if (!s.ut && mPht[s.uidx] != 2'd0) mPht[s.uidx] = mPht[s.uidx] - 2'd1;
      end
      if (s.uv && (s.uj || (s.ub && s.ut))) begin
        mValid[s.upc[7:2]]  = 1'b1;
        mTag[s.upc[7:2]]    = s.upc[15:8];
        mTarget[s.upc[7:2]] = s.utgt;
        mJump[s.upc[7:2]]   = s.uj;
      end
      if (s.uv && (s.ub || s.uj) && mBr != 32'hFFFF_FFFF) mBr = mBr + 32'd1;
      if (s.uv && s.um && mMis != 32'hFFFF_FFFF) mMis = mMis + 32'd1;
      mGhr = ng;
    end
  endtask

  function automatic stim_t mkStim(input logic [31:0] pc, input logic stall, input logic uv,
                                   input logic [31:0] upc, input logic ub, input logic uj,
                                   input logic ut, input logic [31:0] utgt, input logic [5:0] uidx,
                                   input logic [5:0] usnap, input logic um);
    stim_t s;
    s.rst = 1'b0; s.pc = pc; s.stall = stall; s.uv = uv; s.upc = upc;
    s.ub = ub; s.uj = uj; s.ut = ut; s.utgt = utgt; s.uidx = uidx;
    s.usnap = usnap; s.um = um;
    return s;
  endfunction

  function automatic stim_t fetchOnly(input logic [31:0] pc, input logic stall);
    return mkStim(pc, stall, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 6'd0, 6'd0, 1'b0);
  endfunction

  // Drive one step after the falling edge and queue its expectation.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    stepNo++;
    reset         = s.rst;
    pcF           = s.pc;
    stallF        = s.stall;
    updValid      = s.uv;
    updPc         = s.upc;
    updIsBranch   = s.ub;
    updIsJump     = s.uj;
    updTaken      = s.ut;
    updTarget     = s.utgt;
    updPhtIdx     = s.uidx;
    updGhrSnap    = s.usnap;
    updMispredict = s.um;
    if (!s.rst) expQ.push_back(modelPredict(s));
  endtask

  // Compare the DUT against the oldest queued expectation, mid low phase.
  task automatic checkOutput();
    exp_t e;
    #2;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkVal("pred_taken", {31'd0, predTaken}, {31'd0, e.taken});
      checkVal("pred_target", predTarget, e.target);
      checkVal("pht_idx", {26'd0, phtIdx}, {26'd0, e.idx});
      checkVal("ghr_snap", {26'd0, ghrSnap}, {26'd0, e.snap});
      checkVal("perf_branches", perfBranches, e.perfBr);
      checkVal("perf_mispred", perfMispred, e.perfMis);
    end
  endtask

  task automatic doStep(input stim_t s);
    applyStimulus(s);
    checkOutput();
    modelCommit(s);
  endtask

  task automatic doReset(input stim_t s);
    stim_t r;
    r = s;
    r.rst = 1'b1;
    doStep(r);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] pcTab [6];
    stim_t       s;
    int          kind;
    pcTab[0] = 32'h100; pcTab[1] = 32'h104; pcTab[2] = 32'h200;
    pcTab[3] = 32'h1100; pcTab[4] = 32'h2104; pcTab[5] = 32'h308;

    reset = 1'b1; pcF = 32'h100; stallF = 1'b0; updValid = 1'b0; updPc = 32'd0;
    updIsBranch = 1'b0; updIsJump = 1'b0; updTaken = 1'b0; updTarget = 32'd0;
    updPhtIdx = 6'd0; updGhrSnap = 6'd0; updMispredict = 1'b0;
    modelReset();
    $display("[TB] start");

    // Reset state
    doReset(fetchOnly(32'h100, 1'b0));
    doStep(fetchOnly(32'h100, 1'b0));
    checkVal("rst_taken", {31'd0, predTaken}, 32'd0);
    checkVal("rst_target", predTarget, 32'd0);
    checkVal("rst_idx", {26'd0, phtIdx}, 32'd0);

    // Taken beq @0x100 -> 0x80 with mispredict; history becomes 000001
    doStep(mkStim(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 6'd0, 6'd0, 1'b1));
    doStep(mkStim(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 6'd1, 6'd0, 1'b0));
    checkVal("beq_hit_target", predTarget, 32'h80);
    checkVal("beq_snap", {26'd0, ghrSnap}, 32'd1);
    doStep(fetchOnly(32'h100, 1'b0));
    checkVal("beq_taken", {31'd0, predTaken}, 32'd1);

    // Saturation at zero, then climb back; GHR is now 000011 -> idx 3
    for (int i = 0; i < 5; i++)
      doStep(mkStim(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 6'd3, 6'd3, 1'b0));
    doStep(fetchOnly(32'h100, 1'b1));
    checkVal("sat0_taken", {31'd0, predTaken}, 32'd0);
    checkVal("sat0_btb_kept", predTarget, 32'h80);
    for (int i = 0; i < 2; i++)
      doStep(mkStim(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 6'd3, 6'd3, 1'b0));
    doStep(fetchOnly(32'h100, 1'b1));
    checkVal("climb_taken", {31'd0, predTaken}, 32'd1);
    for (int i = 0; i < 3; i++)
      doStep(mkStim(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 6'd3, 6'd3, 1'b0));
    for (int i = 0; i < 2; i++)
      doStep(mkStim(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 6'd3, 6'd3, 1'b0));
    doStep(fetchOnly(32'h100, 1'b1));
    checkVal("sat3_taken", {31'd0, predTaken}, 32'd0);

    // jal @0x200 -> 0x400 (aliases with 0x100)
    doStep(mkStim(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h400, 6'd0, 6'd3, 1'b1));
    doStep(fetchOnly(32'h200, 1'b0));
    checkVal("jal_taken", {31'd0, predTaken}, 32'd1);
    checkVal("jal_target", predTarget, 32'h400);
    doStep(fetchOnly(32'h100, 1'b0));
    checkVal("jal_ghr_kept", {26'd0, ghrSnap}, 32'd3);
    checkVal("alias_miss_taken", {31'd0, predTaken}, 32'd0);

    // Alias 0x1100 overwrites index 0
    doStep(mkStim(32'h100, 1'b1, 1'b1, 32'h1100, 1'b1, 1'b0, 1'b1, 32'h2000, 6'd0, 6'd0, 1'b0));
    doStep(fetchOnly(32'h1100, 1'b1));
    checkVal("alias_target", predTarget, 32'h2000);
    doStep(fetchOnly(32'h100, 1'b1));
    checkVal("alias_old_miss", {31'd0, predTaken}, 32'd0);

    // Recovery beats same-cycle fetch shift
    doStep(mkStim(32'h1100, 1'b0, 1'b1, 32'h304, 1'b1, 1'b0, 1'b1, 32'h500, 6'd5, 6'b101010, 1'b1));
    doStep(fetchOnly(32'h1100, 1'b1));
    checkVal("recover_ghr", {26'd0, ghrSnap}, 32'h15);

    // Not-taken branch does not allocate
    doStep(mkStim(32'h308, 1'b1, 1'b1, 32'h308, 1'b1, 1'b0, 1'b0, 32'h600, 6'd7, 6'd0, 1'b0));
    doStep(fetchOnly(32'h308, 1'b1));
    checkVal("nt_no_alloc", predTarget, 32'd0);

    // upd_valid=0 suppresses everything
    doStep(mkStim(32'h30C, 1'b1, 1'b0, 32'h30C, 1'b1, 1'b0, 1'b1, 32'h700, 6'h15, 6'h3F, 1'b1));
    doStep(fetchOnly(32'h30C, 1'b1));
    checkVal("nv_no_write", predTarget, 32'd0);
    checkVal("nv_ghr_kept", {26'd0, ghrSnap}, 32'h15);

    // Reset wins over a same-cycle update
    doReset(mkStim(32'h310, 1'b0, 1'b1, 32'h310, 1'b1, 1'b0, 1'b1, 32'h800, 6'd0, 6'd7, 1'b1));
    doStep(fetchOnly(32'h310, 1'b1));
    checkVal("rstupd_target", predTarget, 32'd0);
    checkVal("rstupd_ghr", {26'd0, ghrSnap}, 32'd0);
    doStep(fetchOnly(32'h1100, 1'b1));
    checkVal("rstupd_btb_clear", predTarget, 32'd0);

    // Ten resolved control-flow instructions, three mispredicted
    for (int i = 0; i < 10; i++)
      doStep(mkStim(32'h100, 1'b1, 1'b1, 32'h400 + 32'(4 * i), (i % 2) == 0, (i % 2) != 0,
                    1'b1, 32'h900, 6'(i), 6'(i), i < 3));
    doStep(fetchOnly(32'h100, 1'b1));
`ifdef BPU_PERF_EN
    checkVal("perf_br_10", perfBranches, 32'd10);
    checkVal("perf_mis_3", perfMispred, 32'd3);
`else
    checkVal("perf_br_off", perfBranches, 32'd0);
    checkVal("perf_mis_off", perfMispred, 32'd0);
`endif

    // Randomised mix checked against the model
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 2);
      s = mkStim(pcTab[$urandom_range(0, 5)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 pcTab[$urandom_range(0, 5)], kind == 1, kind == 2,
                 (kind == 2) ? 1'b1 : 1'($urandom_range(0, 1)), 32'($urandom),
                 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      doStep(s);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
